knn_dist: RTL and testbench

KNN_DIST -- requirements
Module: knn_dist

---
 rtl/knn_dist_pkg.sv | 24 ++
 rtl/knn_dist_if.sv | 31 +++
 rtl/knn_dist_sq.sv | 38 +++
 rtl/knn_dist.sv | 161 ++++++++++++++++
 tb/tb_knn_dist.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/knn_dist_pkg.sv
`default_nettype none
// ============================================================================
// knn_dist_pkg
// Shared definitions for the k-NN distance engine: FSM state encoding,
// pipeline depth and the all-ones source for the saturation value.
// Rev 1.0 - initial release
// ============================================================================
package knn_dist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Cycles from accepting a point to its result being presented
  localparam int PIPE_DEPTH = 3;

  // Truncated to the distance width to form the saturated result (W <= 64)
  localparam logic [63:0] SAT_ONES = {64{1'b1}};

endpackage
`default_nettype wire

// File: rtl/knn_dist_if.sv
`default_nettype none
// ============================================================================
// knn_dist_if
// Point stream into the distance engine and the distance result out of it.
// Rev 1.0 - initial release
// ============================================================================
interface knn_dist_if #(
  parameter int W = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic signed [W/2-1:0] data_x;
  logic signed [W/2-1:0] data_y;
  logic        [W-1:0]   DATA_OUT;
  logic                  ready;

  // Distance engine side
  modport slave (
    input  in_valid, data_x, data_y,
    output in_ready, DATA_OUT, ready
  );

  // Point source / result consumer side
  modport master (
    output in_valid, data_x, data_y,
    input  in_ready, DATA_OUT, ready
  );

endinterface
`default_nettype wire

// File: rtl/knn_dist_sq.sv
`default_nettype none
// ============================================================================
// knn_sq
// Registered exact squarer of a (W/2+1)-bit signed difference into W bits.
// The magnitude never exceeds 2^(W/2)-1, so the square always fits.
// Rev 1.0 - initial release
// ============================================================================
module knn_sq #(
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic signed [W/2:0] a_i,
  output logic [W-1:0]      sq_o
);

  logic [W/2:0] mag;
  logic [W-1:0] mag_w;
  logic [W-1:0] sq_d;
  logic [W-1:0] sq_q;

  assign mag   = a_i[W/2] ? -a_i : a_i;
  assign mag_w = W'(mag);
  assign sq_d  = mag_w * mag_w;
  assign sq_o  = sq_q;

  // Capture the square whenever the feeding stage holds a valid difference
  always_ff @(posedge clk) begin
    if (!rst) begin
      sq_q <= '0;
    end else if (en_i) begin
      sq_q <= sq_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/knn_dist.sv
`default_nettype none
// ============================================================================
// knn_dist
// Streams data points against a latched test point and emits the saturated
// squared Euclidean distance of each one, in order, three stages later.
// Rev 1.0 - initial release
// ============================================================================
module knn_dist
  import knn_dist_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W/4-1:0]        num_points,
  input  logic signed [W/2-1:0] test_x,
  input  logic signed [W/2-1:0] test_y,
  knn_dist_if.slave             bus,
  output logic                  done,
  output logic                  busy
);

  localparam int CW = W / 4;
  localparam int HW = W / 2;
  localparam int DW = HW + 1;
  localparam logic [W-1:0] SAT = W'(SAT_ONES);

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         num_q;
  logic signed [HW-1:0]  tx_q;
  logic signed [HW-1:0]  ty_q;
  logic                  in_ready_q;
  logic                  done_q;
  logic                  busy_q;

  logic [PIPE_DEPTH-1:0] vld_q;
  logic signed [DW-1:0]  dx_q;
  logic signed [DW-1:0]  dy_q;
  logic signed [DW-1:0]  dx_d;
  logic signed [DW-1:0]  dy_d;
  logic [W-1:0]          sqx;
  logic [W-1:0]          sqy;
  logic [W:0]            sum_d;
  logic [W-1:0]          data_d;
  logic [W-1:0]          data_q;

  logic                  accept;
  logic [CW-1:0]         cnt_inc;
  logic                  drain_end;

  // A start in the same cycle wins over a point on the bus
  assign accept    = bus.in_valid & in_ready_q & ~start;
  assign cnt_inc   = cnt_q + CW'(1);
  // The last point is the youngest in flight, so nothing behind it means done
  assign drain_end = vld_q[2] & ~vld_q[1] & ~vld_q[0];

  assign dx_d   = {bus.data_x[HW-1], bus.data_x} - {tx_q[HW-1], tx_q};
  assign dy_d   = {bus.data_y[HW-1], bus.data_y} - {ty_q[HW-1], ty_q};
  assign sum_d  = {1'b0, sqx} + {1'b0, sqy};
  assign data_d = sum_d[W] ? SAT : sum_d[W-1:0];

  assign bus.in_ready = in_ready_q;
  assign bus.ready    = vld_q[2];
  assign bus.DATA_OUT = data_q;
  assign done         = done_q;
  assign busy         = busy_q;

  // Run control: state, accept counter, latched run parameters, status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      num_q      <= '0;
      tx_q       <= '0;
      ty_q       <= '0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else if (start) begin
      tx_q  <= test_x;
      ty_q  <= test_y;
      num_q <= num_points;
      cnt_q <= '0;
      if (num_points == '0) begin
        state_q    <= ST_DONE;
        in_ready_q <= 1'b0;
        done_q     <= 1'b1;
        busy_q     <= 1'b0;
      end else begin
        state_q    <= ST_RUN;
        in_ready_q <= 1'b1;
        done_q     <= 1'b0;
        busy_q     <= 1'b1;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == num_q) begin
              state_q    <= ST_DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_end) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Datapath: stage valids, difference stage and saturated sum stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q  <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
      data_q <= '0;
    end else begin
      if (start) begin
        vld_q <= '0;
      end else begin
        vld_q <= {vld_q[PIPE_DEPTH-2:0], accept};
      end
      if (accept) begin
        dx_q <= dx_d;
        dy_q <= dy_d;
      end
      if (vld_q[1]) begin
        data_q <= data_d;
      end
    end
  end

  knn_sq #(.W(W)) u_sq_x (
    .clk  (clk),
    .rst  (rst),
    .en_i (vld_q[0]),
    .a_i  (dx_q),
    .sq_o (sqx)
  );

  knn_sq #(.W(W)) u_sq_y (
    .clk  (clk),
    .rst  (rst),
    .en_i (vld_q[0]),
    .a_i  (dy_q),
    .sq_o (sqy)
  );

endmodule
`default_nettype wire

// File: tb/tb_knn_dist.sv
`default_nettype none
// ============================================================================
// tb_knn_dist
// Directed bench for knn_dist with hand-computed expected distances.
// Rev 1.0 - initial release
// ============================================================================
module tb_knn_dist;

  localparam int W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        num_points = 8'd0;
  logic signed [15:0] test_x = 16'sd0;
  logic signed [15:0] test_y = 16'sd0;
  logic              done;
  logic              busy;

  int checks = 0;
  int failures = 0;

  knn_dist_if #(.W(W)) bus ();

  knn_dist #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_points (num_points),
    .test_x     (test_x),
    .test_y     (test_y),
    .bus        (bus),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d (0x%h) expected=%0d (0x%h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic point(input logic signed [15:0] x, input logic signed [15:0] y);
    bus.in_valid = 1'b1;
    bus.data_x   = x;
    bus.data_y   = y;
  endtask

  task automatic no_point();
    bus.in_valid = 1'b0;
  endtask

  // Pulses start for one cycle; returns just after the sampling edge
  task automatic do_start(input logic signed [15:0] tx, input logic signed [15:0] ty,
                          input logic [7:0] n);
    start      = 1'b1;
    test_x     = tx;
    test_y     = ty;
    num_points = n;
    tick();
    start = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.data_x   = 16'sd0;
    bus.data_y   = 16'sd0;

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    chk1("rst_ready", bus.ready, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk32("rst_data", bus.DATA_OUT, 32'd0);
    rst = 1'b1;

    // Points offered in IDLE are ignored
    point(16'sd1, 16'sd1);
    tick();
    tick();
    tick();
    chk1("idle_ready", bus.ready, 1'b0);
    chk1("idle_in_ready", bus.in_ready, 1'b0);
    no_point();

    // Basic: test (0,0), one point (3,4) -> 25
    do_start(16'sd0, 16'sd0, 8'd1);
    chk1("basic_busy", busy, 1'b1);
    chk1("basic_in_ready", bus.in_ready, 1'b1);
    point(16'sd3, 16'sd4);
    tick();
    no_point();
    chk1("basic_in_ready_after", bus.in_ready, 1'b0);
    chk1("basic_ready_c1", bus.ready, 1'b0);
    tick();
    chk1("basic_ready_c2", bus.ready, 1'b0);
    tick();
    chk1("basic_ready_c3", bus.ready, 1'b1);
    chk32("basic_data", bus.DATA_OUT, 32'd25);
    chk1("basic_done_with_ready", done, 1'b0);
    tick();
    chk1("basic_ready_off", bus.ready, 1'b0);
    chk1("basic_done", done, 1'b1);
    chk1("basic_busy_off", busy, 1'b0);
    chk32("basic_data_hold", bus.DATA_OUT, 32'd25);

    // Points offered in DONE are ignored, done holds
    point(16'sd7, 16'sd7);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("done_ignore_ready", bus.ready, 1'b0);
    end
    chk1("done_hold", done, 1'b1);
    no_point();

    // Streaming: test (10,-10), four back-to-back points
    do_start(16'sd10, -16'sd10, 8'd4);
    point(16'sd10, -16'sd10);
    tick();
    point(16'sd13, -16'sd6);
    tick();
    chk1("stream_ready_early", bus.ready, 1'b0);
    point(16'sd0, 16'sd0);
    tick();
    chk1("stream_ready0", bus.ready, 1'b1);
    chk32("stream_data0", bus.DATA_OUT, 32'd0);
    point(-16'sd5, 16'sd10);
    tick();
    chk1("stream_ready1", bus.ready, 1'b1);
    chk32("stream_data1", bus.DATA_OUT, 32'd25);
    chk1("stream_in_ready_full", bus.in_ready, 1'b0);
    no_point();
    tick();
    chk1("stream_ready2", bus.ready, 1'b1);
    chk32("stream_data2", bus.DATA_OUT, 32'd200);
    tick();
    chk1("stream_ready3", bus.ready, 1'b1);
    chk32("stream_data3", bus.DATA_OUT, 32'd625);
    chk1("stream_busy", busy, 1'b1);
    chk1("stream_done_early", done, 1'b0);
    tick();
    chk1("stream_ready_off", bus.ready, 1'b0);
    chk1("stream_done", done, 1'b1);

    // Saturation: far corners of the coordinate range
    do_start(16'sh8000, 16'sh8000, 8'd1);
    point(16'sh7FFF, 16'sh7FFF);
    tick();
    no_point();
    tick();
    tick();
    chk1("sat_ready", bus.ready, 1'b1);
    chk32("sat_data", bus.DATA_OUT, 32'hFFFF_FFFF);
    tick();

    // Gaps: three points with idle cycles between them
    do_start(16'sd0, 16'sd0, 8'd3);
    point(16'sd1, 16'sd0);
    tick();
    no_point();
    tick();
    chk1("gap_ready_e1", bus.ready, 1'b0);
    point(16'sd0, 16'sd2);
    tick();
    chk1("gap_ready_p0", bus.ready, 1'b1);
    chk32("gap_data_p0", bus.DATA_OUT, 32'd1);
    no_point();
    tick();
    chk1("gap_ready_e3", bus.ready, 1'b0);
    chk32("gap_data_hold", bus.DATA_OUT, 32'd1);
    point(16'sd2, 16'sd2);
    tick();
    chk1("gap_ready_p1", bus.ready, 1'b1);
    chk32("gap_data_p1", bus.DATA_OUT, 32'd4);
    no_point();
    tick();
    chk1("gap_ready_e5", bus.ready, 1'b0);
    chk1("gap_in_ready_full", bus.in_ready, 1'b0);
    tick();
    chk1("gap_ready_p2", bus.ready, 1'b1);
    chk32("gap_data_p2", bus.DATA_OUT, 32'd8);
    chk1("gap_done_early", done, 1'b0);
    tick();
    chk1("gap_ready_off", bus.ready, 1'b0);
    chk1("gap_done", done, 1'b1);

    // Restart after 2 of 5 points; start coincides with a valid point
    do_start(16'sd0, 16'sd0, 8'd5);
    point(16'sd1, 16'sd1);
    tick();
    point(16'sd2, 16'sd2);
    tick();
    point(16'sd5, 16'sd5);
    do_start(16'sd0, 16'sd0, 8'd2);
    chk1("restart_flush0", bus.ready, 1'b0);
    chk1("restart_busy", busy, 1'b1);
    chk1("restart_in_ready", bus.in_ready, 1'b1);
    point(16'sd3, 16'sd0);
    tick();
    chk1("restart_flush1", bus.ready, 1'b0);
    chk1("restart_in_ready_cnt1", bus.in_ready, 1'b1);
    point(16'sd0, 16'sd1);
    tick();
    chk1("restart_ready_e4", bus.ready, 1'b0);
    chk1("restart_in_ready_cnt2", bus.in_ready, 1'b0);
    no_point();
    tick();
    chk1("restart_ready0", bus.ready, 1'b1);
    chk32("restart_data0", bus.DATA_OUT, 32'd9);
    tick();
    chk1("restart_ready1", bus.ready, 1'b1);
    chk32("restart_data1", bus.DATA_OUT, 32'd1);
    tick();
    chk1("restart_ready_off", bus.ready, 1'b0);
    chk1("restart_done", done, 1'b1);

    // Reset during DRAIN
    do_start(16'sd0, 16'sd0, 8'd2);
    point(16'sd1, 16'sd1);
    tick();
    point(16'sd2, 16'sd2);
    tick();
    no_point();
    rst = 1'b0;
    tick();
    chk1("drain_rst_ready", bus.ready, 1'b0);
    chk1("drain_rst_done", done, 1'b0);
    chk1("drain_rst_busy", busy, 1'b0);
    chk1("drain_rst_in_ready", bus.in_ready, 1'b0);
    chk32("drain_rst_data", bus.DATA_OUT, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("post_rst_ready", bus.ready, 1'b0);
      chk1("post_rst_busy", busy, 1'b0);
    end
    chk1("post_rst_done", done, 1'b0);
    chk32("post_rst_data", bus.DATA_OUT, 32'd0);

    // N = 0 finishes immediately with no result
    do_start(16'sd0, 16'sd0, 8'd0);
    chk1("n0_done", done, 1'b1);
    chk1("n0_ready", bus.ready, 1'b0);
    chk1("n0_busy", busy, 1'b0);
    chk1("n0_in_ready", bus.in_ready, 1'b0);
    tick();
    chk1("n0_done_hold", done, 1'b1);
    chk1("n0_ready_hold", bus.ready, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
